// File: rtl/mempool_pkg.sv
// mempool_pkg: shared constants, types and helpers for the TCDM bank arbiter.
//
// Contents:
//   idx_width()           - index width for N items (at least 1 bit)
//   tcdm_expects_rsp()    - true when a request is answered by the adapter
//   TcdmArbMaxOutstanding - default in-flight response budget per requester
//   tcdm_arb_idx_t        - requester index type for the tile's arbiter,
//                           NumIn = NumCoresPerTile + NumGroups
package mempool_pkg;

  localparam int unsigned NumCoresPerTile = 4;
  localparam int unsigned NumGroups       = 4;

  // Width needed to index num_idx items; a single item still gets one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

  // Loads, AMOs, LR and SC are answered; only a plain store is not.
  function automatic logic tcdm_expects_rsp(input logic write, input logic [3:0] amo);
    return !write || (amo != 4'h0);
  endfunction

  localparam int unsigned TcdmArbMaxOutstanding = 2;
  localparam int unsigned TcdmArbNumIn          = NumCoresPerTile + NumGroups;

  typedef logic [idx_width(TcdmArbNumIn)-1:0] tcdm_arb_idx_t;

endpackage

// File: rtl/tcdm_bank_arbiter_sel.sv
// tcdm_bank_arbiter_sel: combinational leading-eligible selection.
//
// Scans the eligible vector starting at start_i and wrapping modulo NumIn;
// the first eligible index found wins.
//
// Ports:
//   eligible_i [NumIn]    - per-requester eligibility
//   start_i    [IdxWidth] - index with the highest priority (< NumIn)
//   valid_o               - at least one requester is eligible
//   idx_o      [IdxWidth] - winning index (0 when valid_o is low)
module tcdm_bank_arbiter_sel
  import mempool_pkg::*;
#(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned IdxWidth = idx_width(NumIn)
) (
  input  logic [NumIn-1:0]    eligible_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic                valid_o,
  output logic [IdxWidth-1:0] idx_o
);

  int                  cand;
  logic [IdxWidth-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < int'(NumIn); k++) begin
      // start_i < NumIn, so one conditional subtraction is enough to wrap.
      cand = int'(start_i) + k;
      if (cand >= int'(NumIn)) begin
        cand = cand - int'(NumIn);
      end
      cand_idx = IdxWidth'(cand);
      if (!valid_o && eligible_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// tcdm_bank_arbiter: shares one TCDM bank adapter port between NumIn
// valid/ready requesters and routes responses back by tag.
//
// The requester index is appended in the LSBs of the outgoing metadata and
// responses are steered by that tag, so the adapter may answer out of order
// (deferred LR responses). Per-requester counters bound the responses in
// flight; a grant lock holds the output steady while the adapter stalls.
//
// Configuration macro:
//   TCDM_BANK_ARB_RR_EN - round-robin priority (prio_q); when undefined the
//                         lowest eligible index wins.
//
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   req_*  [NumIn]         - requests from the requesters (valid/ready)
//   rsp_*  [NumIn]         - responses back to the requesters (valid/ready;
//                            rdata/meta broadcast)
//   out_*                  - request towards the bank adapter; out_meta_o is
//                            {req_meta, idx}
//   in_*                   - response from the bank adapter; in_meta_i LSBs
//                            carry the requester tag
//
// Handshake rule for every valid/ready pair: a transfer happens in a cycle
// where valid and ready are both high; once valid is raised the sender keeps
// it and its payload stable until that transfer.
module tcdm_bank_arbiter
  import mempool_pkg::*;
#(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter type         metadata_t     = logic,
  parameter int unsigned MaxOutstanding = TcdmArbMaxOutstanding,
  // Derived; do not override.
  parameter int unsigned IdxWidth       = idx_width(NumIn),
  parameter int unsigned BeWidth        = DataWidth / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  // Requesters
  input  logic [NumIn-1:0]                      req_valid_i,
  output logic [NumIn-1:0]                      req_ready_o,
  input  logic [AddrWidth-1:0]                  req_addr_i  [NumIn],
  input  logic [3:0]                            req_amo_i   [NumIn],
  input  logic [NumIn-1:0]                      req_write_i,
  input  logic [DataWidth-1:0]                  req_wdata_i [NumIn],
  input  logic [BeWidth-1:0]                    req_be_i    [NumIn],
  input  metadata_t                             req_meta_i  [NumIn],
  // Responses to requesters
  output logic [NumIn-1:0]                      rsp_valid_o,
  input  logic [NumIn-1:0]                      rsp_ready_i,
  output logic [DataWidth-1:0]                  rsp_rdata_o,
  output metadata_t                             rsp_meta_o,
  // Request to the bank adapter
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [AddrWidth-1:0]                  out_addr_o,
  output logic [3:0]                            out_amo_o,
  output logic                                  out_write_o,
  output logic [DataWidth-1:0]                  out_wdata_o,
  output logic [BeWidth-1:0]                    out_be_o,
  output logic [$bits(metadata_t)+IdxWidth-1:0] out_meta_o,
  // Response from the bank adapter
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [DataWidth-1:0]                  in_rdata_i,
  input  logic [$bits(metadata_t)+IdxWidth-1:0] in_meta_i
);

  localparam int unsigned CntWidth  = idx_width(MaxOutstanding + 1);
  localparam int unsigned MetaWidth = $bits(metadata_t);

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [IdxWidth-1:0] idx_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  cnt_t cnt_q [NumIn];
  cnt_t cnt_d [NumIn];
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;

  // ---------------------------------------------------------------------
  // Eligibility and selection
  // ---------------------------------------------------------------------
  logic [NumIn-1:0] eligible;
  idx_t             arb_start;
  idx_t             arb_idx;
  logic             arb_valid;
  idx_t             sel;
  logic             req_hs;

  // Registered count only: a response arriving in the same cycle does not
  // make a full requester eligible until the next cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < cnt_t'(MaxOutstanding));
    end
  end

`ifdef TCDM_BANK_ARB_RR_EN
  idx_t prio_q, prio_d;

  assign arb_start = prio_q;

  // Highest priority moves to the requester after the one just served.
  always_comb begin
    prio_d = prio_q;
    if (req_hs) begin
      prio_d = (sel == idx_t'(NumIn - 1)) ? '0 : idx_t'(sel + idx_t'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign arb_start = '0;
`endif

  tcdm_bank_arbiter_sel #(
    .NumIn    (NumIn),
    .IdxWidth (IdxWidth)
  ) i_sel (
    .eligible_i (eligible),
    .start_i    (arb_start),
    .valid_o    (arb_valid),
    .idx_o      (arb_idx)
  );

  // A stalled grant stays on its requester until it is accepted.
  assign sel         = lock_q ? lock_idx_q : arb_idx;
  assign out_valid_o = lock_q || arb_valid;
  assign req_hs      = out_valid_o && out_ready_i;

  assign out_addr_o  = req_addr_i[sel];
  assign out_amo_o   = req_amo_i[sel];
  assign out_write_o = req_write_i[sel];
  assign out_wdata_o = req_wdata_i[sel];
  assign out_be_o    = req_be_i[sel];
  assign out_meta_o  = {req_meta_i[sel], sel};

  // Ready is also qualified with out_valid_o: when nothing is eligible, sel
  // still points somewhere, and a valid-but-ineligible requester there must
  // not see a transfer that never reaches the adapter.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      req_ready_o[i] = out_ready_i && out_valid_o && (sel == idx_t'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Lock
  // ---------------------------------------------------------------------
  always_comb begin
    lock_d     = out_valid_o && !out_ready_i;
    lock_idx_d = lock_idx_q;
    if (out_valid_o && !out_ready_i) begin
      lock_idx_d = sel;
    end
  end

  // ---------------------------------------------------------------------
  // Response routing (purely combinational)
  // ---------------------------------------------------------------------
  idx_t tag;
  logic tag_ok;
  logic rsp_hs;

  assign tag         = in_meta_i[IdxWidth-1:0];
  assign tag_ok      = int'(tag) < int'(NumIn);
  assign in_ready_o  = tag_ok && rsp_ready_i[tag];
  assign rsp_hs      = in_valid_i && in_ready_o;
  assign rsp_rdata_o = in_rdata_i;
  assign rsp_meta_o  = metadata_t'(in_meta_i[MetaWidth+IdxWidth-1:IdxWidth]);

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      rsp_valid_o[i] = in_valid_i && (tag == idx_t'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Outstanding counters
  // ---------------------------------------------------------------------
  logic [NumIn-1:0] cnt_inc;
  logic [NumIn-1:0] cnt_dec;

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      cnt_inc[i] = req_hs && (sel == idx_t'(i)) &&
                   tcdm_expects_rsp(req_write_i[i], req_amo_i[i]);
      cnt_dec[i] = rsp_hs && (tag == idx_t'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NumIn); i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumIn); i++) begin
        cnt_q[i] <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < int'(NumIn); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------
`ifndef SYNTHESIS
  for (genvar g = 0; g < int'(NumIn); g++) begin : g_cnt_chk
    cnt_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cnt_inc[g] && !cnt_dec[g]) |-> (cnt_q[g] < cnt_t'(MaxOutstanding)));
    cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cnt_dec[g] && !cnt_inc[g]) |-> (cnt_q[g] != '0));
  end

  lock_holds_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_valid_i[lock_idx_q]);
`endif

endmodule
